pattern_stream_gen: RTL and testbench
=====================================

// Module: pattern_stream_gen
// PURPOSE
//  Transmit-side companion to the serial pattern detector. Serializes a programmed
//  PAT_W-bit pattern MSB-first onto a 1-bit valid/ready stream, repeated a given
//  number of times, with optional filler bits between repetitions. Drives detector
//  d_i/valid_i directly in block and system benches.
// PARAMETERS
//  PAT_W    4     pattern width in bits (>=2)
//  CNT_W    8     width of repeat count and sent-pattern counter
//  GAP_W    4     width of inter-pattern gap length
//  GAP_BIT  1'b0  value driven on d_o during gap bits
// PORTS
//  clk_i       in   1      clock, all logic on rising edge
//  rst_i       in   1      asynchronous reset, active-high
//  start_i     in   1      start request; sampled only in IDLE
//  pattern_i   in   PAT_W  pattern; captured on accepted start
//  repeat_i    in   CNT_W  number of pattern repetitions; captured on start
//  gap_i       in   GAP_W  filler bits between repetitions; captured on start
//  ready_i     in   1      sink ready; bit transfers when valid_o && ready_i
//  valid_o     out  1      d_o holds a valid stream bit
//  d_o         out  1      serial data bit
//  busy_o      out  1      high from accepted start until done_o cycle inclusive
//  done_o      out  1      1-cycle pulse after final transfer (or empty job)
//  sent_cnt_o  out  CNT_W  patterns fully transferred in current/last job
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; valid_o=0, d_o=0, busy_o=0, done_o=0,
//   sent_cnt_o=0; captured pattern/repeat/gap registers cleared.
//  All outputs registered. States: IDLE, SEND, GAP, DONE.
//  IDLE: start_i=1 at edge t -> capture inputs, sent_cnt_o<=0, busy_o<=1;
//   repeat_i!=0 -> SEND, valid_o=1 with d_o=pattern[PAT_W-1] from cycle t+1;
//   repeat_i==0 -> DONE directly, no bits emitted.
//  SEND: bit index runs PAT_W-1 down to 0; advances only on transfer. On transfer
//   of bit 0: sent_cnt_o+=1; if repetitions done -> DONE; else if gap!=0 -> GAP;
//   else next pattern's MSB follows with no bubble (valid_o stays 1).
//  GAP: drives d_o=GAP_BIT, valid_o=1 for exactly gap transfers, then SEND.
//  Stall: valid_o && !ready_i -> d_o, valid_o, state, counters all hold.
//   valid_o never drops while a bit is pending.
//  DONE: valid_o=0, done_o=1 for one cycle, busy_o=1 this cycle; next -> IDLE.
//  start_i outside IDLE ignored (no capture, no effect on current job).
//  start_i in same cycle as done_o ignored; accepted earliest one cycle later.
//  Changes on pattern_i/repeat_i/gap_i after capture have no effect.
//  sent_cnt_o holds last job's value in IDLE until next accepted start.
//  Throughput: 1 bit/cycle with ready_i=1; job of R reps, gap G takes
//   R*PAT_W + (R-1)*G transfers; done_o one cycle after last transfer.
//  Max repeat 2^CNT_W-1; counters never wrap within a job.
// TESTING
//  1 PAT_W=4, pattern=4'b1011, repeat=3, gap=0, ready=1 -> 12 valid bits
//    101110111011 on consecutive cycles, sent_cnt_o=3, one done_o pulse.
//  2 Same job, gap=2, GAP_BIT=0 -> 1011 00 1011 00 1011 (16 bits), no gap after last.
//  3 ready_i low for 3 cycles mid-pattern -> d_o/valid_o frozen, no bit lost or
//    duplicated; stream identical to scenario 1.
//  4 repeat=0 -> valid_o never high, done_o pulses 2 cycles after start edge,
//    sent_cnt_o=0.
//  5 start_i pulsed again during SEND with different pattern -> ignored; original
//    stream completes unchanged.
//  6 rst_i asserted mid-SEND (between edges) -> valid_o/busy_o drop immediately,
//    state IDLE; new start after release runs a clean job from MSB.
//  Chain to detector (random ready_i, 600 reps) -> detector count matches
//    expected for pattern overlap and sent_cnt_o.

Source files
------------

// File: rtl/pattern_stream_gen.sv
// pattern_stream_gen
//   Serializes a captured PAT_W-bit pattern MSB-first onto a 1-bit valid/ready
//   stream. The pattern is repeated a given number of times, and an optional run
//   of GAP_BIT filler bits separates repetitions. All outputs are registered.
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous reset, active-high
//   start_i     start request, only honoured in idle
//   pattern_i   pattern, captured on an accepted start
//   repeat_i    repetition count, captured on an accepted start (0 = empty job)
//   gap_i       filler bits between repetitions, captured on an accepted start
//   ready_i     sink ready; a bit transfers when valid_o && ready_i
//   valid_o     d_o carries a stream bit
//   d_o         serial data
//   busy_o      job in progress, from accepted start through the done_o cycle
//   done_o      single-cycle end-of-job pulse
//   sent_cnt_o  patterns fully transferred in the current or last job
module pattern_stream_gen #(
  parameter int unsigned PAT_W   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned GAP_W   = 4,
  parameter logic        GAP_BIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic             d_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_cnt_o
);

  localparam int unsigned IdxW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              valid_q, valid_d;
  logic              d_q, d_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IdxW-1:0]   idx_dec;
  logic [CNT_W-1:0]  sent_inc;

  assign idx_dec  = bit_idx_q - IdxW'(1);
  assign sent_inc = sent_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_idx_d = bit_idx_q;
    sent_d    = sent_q;
    valid_d   = valid_q;
    d_d       = d_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          pat_d  = pattern_i;
          rep_d  = repeat_i;
          gap_d  = gap_i;
          sent_d = '0;
          busy_d = 1'b1;
          if (repeat_i != '0) begin
            state_d   = StSend;
            valid_d   = 1'b1;
            d_d       = pattern_i[PAT_W-1];
            bit_idx_d = IdxMsb;
          end else begin
            state_d = StDone;
          end
        end
      end

      StSend: begin
        // Everything holds while the sink stalls.
        if (ready_i) begin
          if (bit_idx_q != '0) begin
            bit_idx_d = idx_dec;
            d_d       = pat_q[idx_dec];
          end else begin
            sent_d = sent_inc;
            if (sent_inc == rep_q) begin
              state_d = StDone;
              valid_d = 1'b0;
              d_d     = 1'b0;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d   = StGap;
              gap_cnt_d = gap_q - GAP_W'(1);
              d_d       = GAP_BIT;
            end else begin
              // Back-to-back repetition: next MSB with no bubble.
              bit_idx_d = IdxMsb;
              d_d       = pat_q[PAT_W-1];
            end
          end
        end
      end

      StGap: begin
        // gap_cnt_q counts filler bits still to go after the current one.
        if (ready_i) begin
          if (gap_cnt_q == '0) begin
            state_d   = StSend;
            bit_idx_d = IdxMsb;
            d_d       = pat_q[PAT_W-1];
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
      end

      StDone: begin
        // Entered with done_q already set after a real job; an empty job
        // arrives with done_q clear and spends one extra cycle here first.
        if (done_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        d_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_idx_q <= '0;
      sent_q    <= '0;
      valid_q   <= 1'b0;
      d_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_idx_q <= bit_idx_d;
      sent_q    <= sent_d;
      valid_q   <= valid_d;
      d_q       <= d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign valid_o    = valid_q;
  assign d_o        = d_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sent_cnt_o = sent_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Directed bench for pattern_stream_gen with default parameters.
module tb_pattern_stream_gen;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [3:0] pattern_i;
  logic [7:0] repeat_i;
  logic [3:0] gap_i;
  logic       ready_i;
  logic       valid_o;
  logic       d_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sent_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] got;
  int nbits, nvalid, ncyc;

  pattern_stream_gen #(
    .PAT_W  (4),
    .CNT_W  (8),
    .GAP_W  (4),
    .GAP_BIT(1'b0)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .pattern_i (pattern_i),
    .repeat_i  (repeat_i),
    .gap_i     (gap_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .d_o       (d_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sent_cnt_o(sent_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Called just after an edge; leaves us just after the accepting edge.
  task automatic start_job(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    pattern_i = p;
    repeat_i  = r;
    gap_i     = g;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  // Records transferred bits until done_o, with an optional ready_i stall and an
  // optional stray start pulse. Returns just after the edge ending the done cycle.
  task automatic collect(input int stall_at, input int stall_len, input bit poke);
    int   stall_left;
    bit   poked;
    bit   have_prev;
    logic prev_d;
    bit   seen_done;
    stall_left = stall_len;
    poked      = 1'b0;
    have_prev  = 1'b0;
    prev_d     = 1'b0;
    seen_done  = 1'b0;
    got        = '0;
    nbits      = 0;
    nvalid     = 0;
    ncyc       = 0;
    while (ncyc < 200 && !seen_done) begin
      @(negedge clk_i);
      ncyc++;
      if (valid_o) nvalid++;
      if (valid_o && !ready_i) begin
        if (have_prev) check("stall_hold_d", 64'(d_o), 64'(prev_d));
        prev_d    = d_o;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
      if (valid_o && ready_i) begin
        got = {got[62:0], d_o};
        nbits++;
      end
      if (done_o) seen_done = 1'b1;
      if (!seen_done) begin
        step();
        start_i = 1'b0;
        if (stall_left > 0 && nbits == stall_at) begin
          ready_i = 1'b0;
          stall_left--;
        end else begin
          ready_i = 1'b1;
        end
        if (poke && !poked && nbits == 5) begin
          start_i   = 1'b1;
          pattern_i = 4'b0100;
          repeat_i  = 8'd7;
          gap_i     = 4'd3;
          poked     = 1'b1;
        end
      end
    end
    check("done_seen", 64'(seen_done), 64'd1);
    step();
  endtask

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    ready_i   = 1'b1;
    pattern_i = '0;
    repeat_i  = '0;
    gap_i     = '0;
    #12;
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_d", 64'(d_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_sent", 64'(sent_cnt_o), 64'd0);
    step();
    rst_i = 1'b0;
    step();

    // 1: 1011 x3, no gap, ready always high.
    start_job(4'b1011, 8'd3, 4'd0);
    check("s1_first_valid", 64'(valid_o), 64'd1);
    check("s1_first_d", 64'(d_o), 64'd1);
    check("s1_busy", 64'(busy_o), 64'd1);
    collect(-1, 0, 1'b0);
    check("s1_stream", got, 64'hBBB);
    check("s1_nbits", 64'(nbits), 64'd12);
    check("s1_nvalid", 64'(nvalid), 64'd12);
    check("s1_cycles", 64'(ncyc), 64'd13);
    check("s1_sent", 64'(sent_cnt_o), 64'd3);
    check("s1_done_low", 64'(done_o), 64'd0);
    check("s1_busy_low", 64'(busy_o), 64'd0);
    check("s1_valid_low", 64'(valid_o), 64'd0);
    step();
    check("s1_sent_hold", 64'(sent_cnt_o), 64'd3);

    // 2: gap of two filler zeros between repetitions only.
    start_job(4'b1011, 8'd3, 4'd2);
    check("s2_sent_clr", 64'(sent_cnt_o), 64'd0);
    collect(-1, 0, 1'b0);
    check("s2_stream", got, 64'hB2CB);
    check("s2_nbits", 64'(nbits), 64'd16);
    check("s2_cycles", 64'(ncyc), 64'd17);
    check("s2_sent", 64'(sent_cnt_o), 64'd3);

    // 3: three-cycle stall after six bits.
    start_job(4'b1011, 8'd3, 4'd0);
    collect(6, 3, 1'b0);
    check("s3_stream", got, 64'hBBB);
    check("s3_nbits", 64'(nbits), 64'd12);
    check("s3_nvalid", 64'(nvalid), 64'd15);
    check("s3_sent", 64'(sent_cnt_o), 64'd3);

    // 4: empty job.
    start_job(4'b1011, 8'd0, 4'd0);
    check("s4_t1_valid", 64'(valid_o), 64'd0);
    check("s4_t1_busy", 64'(busy_o), 64'd1);
    check("s4_t1_done", 64'(done_o), 64'd0);
    step();
    check("s4_t2_valid", 64'(valid_o), 64'd0);
    check("s4_t2_done", 64'(done_o), 64'd1);
    check("s4_t2_busy", 64'(busy_o), 64'd1);
    check("s4_sent", 64'(sent_cnt_o), 64'd0);
    step();
    check("s4_t3_done", 64'(done_o), 64'd0);
    check("s4_t3_busy", 64'(busy_o), 64'd0);

    // 5: stray start mid-job must not disturb the stream.
    start_job(4'b1011, 8'd3, 4'd0);
    collect(-1, 0, 1'b1);
    check("s5_stream", got, 64'hBBB);
    check("s5_nbits", 64'(nbits), 64'd12);
    check("s5_sent", 64'(sent_cnt_o), 64'd3);
    step();
    check("s5_idle_valid", 64'(valid_o), 64'd0);

    // 6: asynchronous reset mid-send, then a clean job.
    start_job(4'b1011, 8'd3, 4'd0);
    step();
    step();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("s6_rst_valid", 64'(valid_o), 64'd0);
    check("s6_rst_busy", 64'(busy_o), 64'd0);
    check("s6_rst_d", 64'(d_o), 64'd0);
    check("s6_rst_sent", 64'(sent_cnt_o), 64'd0);
    step();
    rst_i = 1'b0;
    step();
    check("s6_idle_valid", 64'(valid_o), 64'd0);
    start_job(4'b1100, 8'd1, 4'd0);
    check("s6_first_d", 64'(d_o), 64'd1);
    collect(-1, 0, 1'b0);
    check("s6_stream", got, 64'hC);
    check("s6_nbits", 64'(nbits), 64'd4);
    check("s6_sent", 64'(sent_cnt_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
